// File: rtl/store_narrow_rmw.sv
// store_narrow_rmw: store-path narrowing unit for the word-wide data memory.
// Word stores are written directly. Byte and halfword stores read the
// containing word, splice the addressed little-endian lane in, and write the
// merged word back. Malformed requests complete with err and touch no memory.
module store_narrow_rmw #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_rdata,
  output logic        mem_wr,
  output logic [31:0] mem_wdata
);

  localparam int DATA_W = 32;
  localparam int CNT_W  = 3;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Wait-counter reload: the counter runs READ_LATENCY-1 .. 0, one WAIT
  // cycle per count, so WAIT lasts exactly READ_LATENCY cycles.
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  // Request captured at acceptance (stage 0) and read word captured at the
  // end of WAIT (stage 1).
  logic [DATA_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [1:0]        size_p0;
  logic              err_p0;
  logic [DATA_W-1:0] rdata_p1;
  logic [CNT_W-1:0]  cnt_p0;

  logic              accept;
  logic              req_bad;
  logic              wait_last;
  logic [DATA_W-1:0] merged;

  // A request is malformed when its size code is reserved or the address is
  // not naturally aligned for the access width. Byte stores are always legal.
  function automatic logic is_reject(input logic [1:0] sz, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (sz)
      SZ_WORD: bad = (lo != 2'b00);
      SZ_HALF: bad = lo[0];
      SZ_BYTE: bad = 1'b0;
      SZ_RSVD: bad = 1'b1;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Splice the store data into the old word. Lanes are little-endian: byte
  // lane k is bits [8k+7:8k], half lane h is bits [16h+15:16h]. Every bit
  // outside the selected lane comes from the old word unchanged; store data
  // bits above the lane width are never used. Word stores take data as is.
  function automatic logic [DATA_W-1:0] lane_merge(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] data,
    input logic [1:0]        sz,
    input logic [1:0]        lane
  );
    logic [DATA_W-1:0] res;
    res = old_word;
    case (sz)
      SZ_BYTE: begin
        case (lane)
          2'd0:    res[7:0]   = data[7:0];
          2'd1:    res[15:8]  = data[7:0];
          2'd2:    res[23:16] = data[7:0];
          default: res[31:24] = data[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) begin
          res[31:16] = data[15:0];
        end else begin
          res[15:0] = data[15:0];
        end
      end
      default: res = data;
    endcase
    return res;
  endfunction

  assign accept    = (state == S_IDLE) && start;
  assign req_bad   = is_reject(size, addr[1:0]);
  assign wait_last = (state == S_WAIT) && (cnt_p0 == '0);
  assign merged    = lane_merge(rdata_p1, wdata_p0, size_p0, addr_p0[1:0]);

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- stage 0: request capture, only when accepted in IDLE ----
  // Request latch; starts arriving while busy never reach these registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_p0  <= '0;
      wdata_p0 <= '0;
      size_p0  <= SZ_WORD;
      err_p0   <= 1'b0;
    end else if (accept) begin
      addr_p0  <= addr;
      wdata_p0 <= wdata;
      size_p0  <= size;
      err_p0   <= req_bad;
    end
  end

  // ---- stage 1: read-latency wait and read-data capture ----
  // Latency counter and capture of the word returned on the last WAIT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p0   <= '0;
      rdata_p1 <= '0;
    end else begin
      if (state == S_READ) begin
        cnt_p0 <= WAIT_LOAD;
      end else if ((state == S_WAIT) && (cnt_p0 != '0)) begin
        cnt_p0 <= cnt_p0 - 1'b1;
      end
      if (wait_last) begin
        rdata_p1 <= mem_rdata;
      end
    end
  end

  // Next-state logic and output decode; outputs depend only on registers.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (req_bad) begin
            state_nxt = S_DONE;
          end else if (size == SZ_WORD) begin
            state_nxt = S_WRITE;
          end else begin
            state_nxt = S_READ;
          end
        end
      end
      S_READ: begin
        mem_rd    = 1'b1;
        mem_addr  = {addr_p0[31:2], 2'b00};
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        mem_addr = {addr_p0[31:2], 2'b00};
        if (cnt_p0 == '0) begin
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        mem_wr    = 1'b1;
        mem_addr  = {addr_p0[31:2], 2'b00};
        mem_wdata = merged;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        err       = err_p0;
        state_nxt = S_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_store_narrow_rmw.sv
// Bench for store_narrow_rmw: two instances (read latency 1 and 3) share one
// stimulus stream. A transaction-level model predicts each output per cycle
// from the request and a word-array memory; directed cases pin the model with
// hand-computed literals.
module tb_store_narrow_rmw;

  localparam int RL0   = 1;
  localparam int RL1   = 3;
  localparam int NRAND = 250;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  size  = 2'b00;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic        busy      [2];
  logic        done      [2];
  logic        err       [2];
  logic        mem_rd    [2];
  logic        mem_wr    [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];

  store_narrow_rmw #(.READ_LATENCY(RL0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .size(size), .addr(addr), .wdata(wdata),
    .busy(busy[0]), .done(done[0]), .err(err[0]), .mem_addr(mem_addr[0]),
    .mem_rd(mem_rd[0]), .mem_rdata(mem_rdata[0]), .mem_wr(mem_wr[0]),
    .mem_wdata(mem_wdata[0])
  );

  store_narrow_rmw #(.READ_LATENCY(RL1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .size(size), .addr(addr), .wdata(wdata),
    .busy(busy[1]), .done(done[1]), .err(err[1]), .mem_addr(mem_addr[1]),
    .mem_rd(mem_rd[1]), .mem_rdata(mem_rdata[1]), .mem_wr(mem_wr[1]),
    .mem_wdata(mem_wdata[1])
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Memory image per instance, indexed by address bits [9:2].
  logic [31:0] mem [2][256];

  // Model of the accepted transaction: phase = cycles since acceptance (0 = idle).
  int          phase  [2];
  int          len    [2];
  bit          rej    [2];
  bit          sub    [2];
  logic [31:0] t_addr [2];
  logic [31:0] t_word [2];

  // Memory responder and observation records.
  bit          rd_pend  [2];
  int          rd_due   [2];
  logic [31:0] rd_word  [2];
  int          rd_cnt   [2];
  int          wr_cnt   [2];
  int          err_cnt  [2];
  int          wr_cyc   [2];
  int          done_cyc [2];
  logic [31:0] last_wr  [2];
  logic [31:0] last_wa  [2];
  int          rd0 [2];
  int          wr0 [2];
  int          er0 [2];

  function automatic int rl(input int i);
    return (i == 0) ? RL0 : RL1;
  endfunction

  task automatic check(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", nm, i, cyc, act, exp);
    end
  endtask

  // Model acceptance: work out the whole transaction from the request.
  task automatic accept(input int i);
    logic [31:0] w;
    int          k;
    t_addr[i] = addr;
    rej[i] = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
             (size == 2'b00 && addr[1:0] != 2'b00);
    sub[i] = (size == 2'b01) || (size == 2'b10);
    len[i] = rej[i] ? 1 : (sub[i] ? 3 + rl(i) : 2);
    if (sub[i]) begin
      w = mem[i][addr[9:2]];
      if (size == 2'b10) begin
        k = int'(addr[1:0]);
        w[8*k +: 8] = wdata[7:0];
      end else begin
        k = int'(addr[1]);
        w[16*k +: 16] = wdata[15:0];
      end
    end else begin
      w = wdata;
    end
    t_word[i] = w;
    phase[i] = 1;
  endtask

  // Per-cycle compare, memory behaviour and model advance for instance i.
  task automatic step(input int i);
    bit          eb, ed, ee, er, ew, ca;
    int          k;
    logic [31:0] ea;
    if (rst) begin
      check("rst_busy",  i, 32'(busy[i]),   32'd0);
      check("rst_done",  i, 32'(done[i]),   32'd0);
      check("rst_err",   i, 32'(err[i]),    32'd0);
      check("rst_rd",    i, 32'(mem_rd[i]), 32'd0);
      check("rst_wr",    i, 32'(mem_wr[i]), 32'd0);
      check("rst_addr",  i, mem_addr[i],    32'd0);
      check("rst_wdata", i, mem_wdata[i],   32'd0);
      phase[i]   = 0;
      rd_pend[i] = 1'b0;
      return;
    end
    eb = 0; ed = 0; ee = 0; er = 0; ew = 0; ca = 1; ea = '0;
    if (phase[i] > 0) begin
      k  = phase[i];
      eb = 1;
      ed = (k == len[i]);
      ee = ed && rej[i];
      er = !rej[i] && sub[i] && (k == 1);
      ew = !rej[i] && ((!sub[i] && k == 1) || (sub[i] && k == 2 + rl(i)));
      ca = !rej[i] && (k < len[i]);
      ea = {t_addr[i][31:2], 2'b00};
    end
    check("busy",   i, 32'(busy[i]),   32'(eb));
    check("done",   i, 32'(done[i]),   32'(ed));
    check("err",    i, 32'(err[i]),    32'(ee));
    check("mem_rd", i, 32'(mem_rd[i]), 32'(er));
    check("mem_wr", i, 32'(mem_wr[i]), 32'(ew));
    if (ca) check("mem_addr", i, mem_addr[i], ea);
    if (ew) check("mem_wdata", i, mem_wdata[i], t_word[i]);
    if (mem_rd[i] === 1'b1) begin
      rd_cnt[i]++;
      rd_pend[i] = 1'b1;
      rd_due[i]  = cyc + rl(i);
      rd_word[i] = mem[i][mem_addr[i][9:2]];
    end
    if (mem_wr[i] === 1'b1) begin
      wr_cnt[i]++;
      wr_cyc[i]  = cyc;
      last_wr[i] = mem_wdata[i];
      last_wa[i] = mem_addr[i];
      mem[i][mem_addr[i][9:2]] = mem_wdata[i];
    end
    if (done[i] === 1'b1) done_cyc[i] = cyc;
    if (err[i] === 1'b1) err_cnt[i]++;
    if (phase[i] == 0) begin
      if (start) accept(i);
    end else if (phase[i] == len[i]) begin
      phase[i] = 0;
    end else begin
      phase[i]++;
    end
  endtask

  // One clock: drive inputs just after the rising edge, check at the falling edge.
  task automatic run_cycle(input bit st, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] d, input bit r);
    @(posedge clk);
    cyc++;
    #1;
    rst   = r;
    start = st;
    size  = sz;
    addr  = a;
    wdata = d;
    for (int i = 0; i < 2; i++)
      mem_rdata[i] = (rd_pend[i] && rd_due[i] == cyc) ? rd_word[i] : $urandom;
    @(negedge clk);
    for (int i = 0; i < 2; i++) step(i);
  endtask

  task automatic idle_cycle(input bit r);
    run_cycle(1'b0, 2'($urandom_range(0, 3)), $urandom, $urandom, r);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      idle_cycle(1'b0);
      n++;
    end while ((busy[0] || busy[1]) && n < 60);
    if (busy[0] || busy[1]) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout cyc=%0d got=busy want=idle", cyc);
    end
  endtask

  task automatic snap();
    for (int i = 0; i < 2; i++) begin
      rd0[i] = rd_cnt[i];
      wr0[i] = wr_cnt[i];
      er0[i] = err_cnt[i];
    end
  endtask

  task automatic issue(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                       output int t0);
    snap();
    t0 = cyc + 1;
    run_cycle(1'b1, sz, a, d, 1'b0);
    wait_idle();
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    mem[0][a[9:2]] = v;
    mem[1][a[9:2]] = v;
  endtask

  task automatic lit_sub(input string nm, input logic [31:0] exp, input logic [31:0] ea, input int t0);
    for (int i = 0; i < 2; i++) begin
      check({nm, "_data"},  i, last_wr[i], exp);
      check({nm, "_addr"},  i, last_wa[i], ea);
      check({nm, "_wrcyc"}, i, 32'(wr_cyc[i] - t0),   32'(2 + rl(i)));
      check({nm, "_dncyc"}, i, 32'(done_cyc[i] - t0), 32'(3 + rl(i)));
      check({nm, "_nrd"},   i, 32'(rd_cnt[i] - rd0[i]), 32'd1);
      check({nm, "_nwr"},   i, 32'(wr_cnt[i] - wr0[i]), 32'd1);
    end
  endtask

  task automatic lit_rej(input string nm, input int t0);
    for (int i = 0; i < 2; i++) begin
      check({nm, "_dncyc"}, i, 32'(done_cyc[i] - t0), 32'd1);
      check({nm, "_nerr"},  i, 32'(err_cnt[i] - er0[i]), 32'd1);
      check({nm, "_nrd"},   i, 32'(rd_cnt[i] - rd0[i]), 32'd0);
      check({nm, "_nwr"},   i, 32'(wr_cnt[i] - wr0[i]), 32'd0);
    end
  endtask

  initial begin
    int          t0;
    bit          extra;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] d;
    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w < 256; w++) mem[i][w] = $urandom;
      phase[i] = 0; len[i] = 0; rej[i] = 0; sub[i] = 0;
      t_addr[i] = '0; t_word[i] = '0;
      rd_pend[i] = 0; rd_due[i] = 0; rd_word[i] = '0;
      rd_cnt[i] = 0; wr_cnt[i] = 0; err_cnt[i] = 0; wr_cyc[i] = 0; done_cyc[i] = 0;
      last_wr[i] = '0; last_wa[i] = '0;
      mem_rdata[i] = '0;
    end

    // Reset held with start toggling; nothing may happen.
    repeat (3) run_cycle(1'b1, 2'b10, $urandom, $urandom, 1'b1);
    idle_cycle(1'b0);
    for (int i = 0; i < 2; i++) begin
      check("post_rst_busy", i, 32'(busy[i]), 32'd0);
      check("post_rst_nwr",  i, 32'(wr_cnt[i]), 32'd0);
    end

    // Word store.
    issue(2'b00, 32'h0000_0104, 32'hDEAD_BEEF, t0);
    for (int i = 0; i < 2; i++) begin
      check("sw_data",  i, last_wr[i], 32'hDEAD_BEEF);
      check("sw_addr",  i, last_wa[i], 32'h0000_0104);
      check("sw_wrcyc", i, 32'(wr_cyc[i] - t0), 32'd1);
      check("sw_dncyc", i, 32'(done_cyc[i] - t0), 32'd2);
      check("sw_nrd",   i, 32'(rd_cnt[i] - rd0[i]), 32'd0);
      check("sw_nwr",   i, 32'(wr_cnt[i] - wr0[i]), 32'd1);
    end

    // Byte and halfword stores into a known word.
    preload(32'h100, 32'h1122_3344);
    issue(2'b10, 32'h0000_0102, 32'hFFFF_FFAB, t0);
    lit_sub("sb102", 32'h11AB_3344, 32'h0000_0100, t0);
    preload(32'h100, 32'h1122_3344);
    issue(2'b01, 32'h0000_0102, 32'h1234_BEEF, t0);
    lit_sub("sh102", 32'hBEEF_3344, 32'h0000_0100, t0);
    preload(32'h100, 32'h1122_3344);
    issue(2'b01, 32'h0000_0100, 32'h1234_BEEF, t0);
    lit_sub("sh100", 32'h1122_BEEF, 32'h0000_0100, t0);

    // Rejected requests.
    issue(2'b01, 32'h0000_0101, 32'h1234_5678, t0);
    lit_rej("sh_odd", t0);
    issue(2'b11, 32'h0000_0100, 32'h1234_5678, t0);
    lit_rej("rsvd", t0);
    issue(2'b00, 32'h0000_0106, 32'h1234_5678, t0);
    lit_rej("sw_mis", t0);

    // Top byte lane, with a second start during the operation.
    preload(32'h100, 32'hAABB_CCDD);
    snap();
    t0 = cyc + 1;
    run_cycle(1'b1, 2'b10, 32'h0000_0103, 32'h0000_0055, 1'b0);
    idle_cycle(1'b0);
    run_cycle(1'b1, 2'b00, 32'h0000_0200, 32'h1234_5678, 1'b0);
    wait_idle();
    lit_sub("sb103", 32'h55BB_CCDD, 32'h0000_0100, t0);

    // Reset during WAIT aborts without a write; a fresh store then completes.
    preload(32'h100, 32'h1122_3344);
    snap();
    run_cycle(1'b1, 2'b10, 32'h0000_0101, 32'h0000_0077, 1'b0);
    idle_cycle(1'b0);
    idle_cycle(1'b1);
    for (int i = 0; i < 2; i++) check("async_rst_busy", i, 32'(busy[i]), 32'd0);
    idle_cycle(1'b1);
    repeat (6) idle_cycle(1'b0);
    for (int i = 0; i < 2; i++) check("abort_nwr", i, 32'(wr_cnt[i] - wr0[i]), 32'd0);
    issue(2'b00, 32'h0000_0300, 32'hCAFE_F00D, t0);
    for (int i = 0; i < 2; i++) begin
      check("after_rst_data",  i, last_wr[i], 32'hCAFE_F00D);
      check("after_rst_wrcyc", i, 32'(wr_cyc[i] - t0), 32'd1);
    end

    // Randomized traffic, mostly legal, sometimes with extra starts while busy.
    for (int n = 0; n < NRAND; n++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      d  = $urandom;
      if ($urandom_range(0, 1) == 0) a[9:5] = '0;
      if ($urandom_range(0, 9) < 7) begin
        if (sz == 2'b11) sz = 2'($urandom_range(0, 2));
        if (sz == 2'b00) a[1:0] = 2'b00;
        if (sz == 2'b01) a[0] = 1'b0;
      end
      extra = ($urandom_range(0, 3) == 0);
      run_cycle(1'b1, sz, a, d, 1'b0);
      for (int j = 0; j < 3; j++)
        run_cycle(extra && (j == 1), 2'($urandom_range(0, 3)), $urandom, $urandom, 1'b0);
      wait_idle();
      repeat ($urandom_range(0, 2)) idle_cycle(1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
